// File: rtl/alu_sequencer_pkg.sv
// ============================================================================
// Module      : alu_sequencer_pkg
// Description : Shared op codes, FSM state encoding and defaults for the ALU
//               sequencer and its settle timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_sequencer_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int SETTLE_CNT_W  = 4;

  localparam logic [1:0] OP_LDN = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_CMP = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DRIVE   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic logic is_arith(input logic [1:0] op);
    return op != OP_CMP;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_seq_settle_timer.sv
// ============================================================================
// Module      : alu_seq_settle_timer
// Description : Loadable down-counter; o_expired pulses on the last enabled
//               count so the caller leaves its wait state on time.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_seq_settle_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Expiry on the count of 1 makes a load of N give exactly N enabled cycles.
  assign o_expired = i_en && (r_cnt == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module      : alu_sequencer
// Description : Drives the combinational ALU for LDN/SUB/ADD/CMP under a
//               start/done handshake and captures RESULT into the accumulator.
//               Optional signed-overflow flag: define ALU_SEQ_OVERFLOW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] acc,
  output logic             skip,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic             alu_sub,
  output logic             alu_oe_n,
`ifdef ALU_SEQ_OVERFLOW_EN
  output logic             overflow,
`endif
  input  logic [WIDTH-1:0] alu_result
);

  localparam int MSB = WIDTH - 1;

  state_e r_state;
  state_e w_state_nxt;
  logic   w_accept;
  logic   w_timer_load;
  logic   w_timer_en;
  logic   w_expired;

  assign w_accept = (r_state == ST_IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_timer_load = 1'b0;
    w_timer_en   = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = is_arith(op) ? ST_DRIVE : ST_DONE;
        end
      end
      ST_DRIVE: begin
        busy         = 1'b1;
        w_timer_load = 1'b1;
        w_state_nxt  = ST_SETTLE;
      end
      ST_SETTLE: begin
        busy       = 1'b1;
        w_timer_en = 1'b1;
        if (w_expired) begin
          w_state_nxt = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        busy        = 1'b1;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done        = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  alu_seq_settle_timer #(
    .CNT_W(SETTLE_CNT_W)
  ) u_settle_timer (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_timer_load),
    .i_load_val (SETTLE_CNT_W'(SETTLE_CYCLES)),
    .i_en       (w_timer_en),
    .o_expired  (w_expired)
  );

  // The ALU operand registers double as the latched op/operand: they are
  // loaded on accept so the ALU is already driven throughout DRIVE.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc      <= '0;
      skip     <= 1'b0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_sub  <= 1'b0;
      alu_oe_n <= 1'b1;
`ifdef ALU_SEQ_OVERFLOW_EN
      overflow <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        if (op == OP_CMP) begin
          skip <= acc[MSB];
        end else begin
          alu_a    <= (op == OP_LDN) ? '0 : acc;
          alu_b    <= operand;
          alu_sub  <= (op != OP_ADD);
          alu_oe_n <= 1'b0;
        end
      end
      if (r_state == ST_CAPTURE) begin
        acc      <= alu_result;
        alu_oe_n <= 1'b1;
`ifdef ALU_SEQ_OVERFLOW_EN
        if (alu_sub) begin
          overflow <= (alu_a[MSB] != alu_b[MSB]) && (alu_result[MSB] != alu_a[MSB]);
        end else begin
          overflow <= (alu_a[MSB] == alu_b[MSB]) && (alu_result[MSB] != alu_a[MSB]);
        end
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer with a behavioural ALU
//               and an arithmetic reference model of the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int WIDTH  = 32;
  localparam int SETTLE = 3;
  localparam int MAXCYC = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [1:0]        op;
  logic [WIDTH-1:0]  operand;
  logic              busy, done, skip, alu_sub, alu_oe_n;
  logic [WIDTH-1:0]  acc, alu_a, alu_b, alu_result;
  logic [WIDTH-1:0]  garbage = '0;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic              overflow;
  logic              ovf_m = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] acc_m  = '0;
  logic             skip_m = 1'b0;

  alu_sequencer #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .operand    (operand),
    .busy       (busy),
    .done       (done),
    .acc        (acc),
    .skip       (skip),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sub    (alu_sub),
    .alu_oe_n   (alu_oe_n),
`ifdef ALU_SEQ_OVERFLOW_EN
    .overflow   (overflow),
`endif
    .alu_result (alu_result)
  );

  always #5 clk = ~clk;

  // Behavioural ALU; junk on the bus whenever its output is disabled.
  always @(negedge clk) garbage = $urandom;
  assign alu_result = alu_oe_n ? garbage : (alu_sub ? alu_a - alu_b : alu_a + alu_b);

  // Runs one op starting from a negedge in IDLE; returns at a negedge in IDLE.
  // poke_cyc > 0 pulses a competing ADD start at that cycle after accept.
  task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] v, input int poke_cyc);
    int cyc;
    int exp_lat;
    logic [WIDTH-1:0] exp_acc;
    logic exp_skip;
    longint s;
    exp_acc  = acc_m;
    exp_skip = skip_m;
    s        = 0;
    case (o)
      OP_LDN: begin exp_acc = -v;         s = -longint'($signed(v)); end
      OP_SUB: begin exp_acc = acc_m - v;  s = longint'($signed(acc_m)) - longint'($signed(v)); end
      OP_ADD: begin exp_acc = acc_m + v;  s = longint'($signed(acc_m)) + longint'($signed(v)); end
      default: exp_skip = acc_m[WIDTH-1];
    endcase
    exp_lat = (o == OP_CMP) ? 1 : SETTLE + 3;
    start = 1'b1; op = o; operand = v;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); operand = $urandom;
    cyc = 1;
    while (done !== 1'b1 && cyc < MAXCYC) begin
      if (cyc == poke_cyc) begin
        n_checks++;
        if (busy !== 1'b1) $display("FAIL busy_mid_op: busy=%b required 1", busy);
        else n_pass++;
        start = 1'b1; op = OP_ADD; operand = 32'h12345678;
      end
      @(negedge clk);
      start = 1'b0; op = 2'($urandom); operand = $urandom;
      cyc++;
    end
    n_checks++;
    if (cyc !== exp_lat) $display("FAIL latency op=%0d: got %0d cycles required %0d", o, cyc, exp_lat);
    else n_pass++;
    n_checks++;
    if (acc !== exp_acc) $display("FAIL acc op=%0d operand=%h: got %h required %h", o, v, acc, exp_acc);
    else n_pass++;
    n_checks++;
    if (skip !== exp_skip) $display("FAIL skip op=%0d: got %b required %b", o, skip, exp_skip);
    else n_pass++;
    n_checks++;
    if (alu_oe_n !== 1'b1 || busy !== 1'b0) $display("FAIL oe_busy_at_done: oe_n=%b busy=%b required 1/0", alu_oe_n, busy);
    else n_pass++;
`ifdef ALU_SEQ_OVERFLOW_EN
    if (o != OP_CMP) ovf_m = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    n_checks++;
    if (overflow !== ovf_m) $display("FAIL overflow op=%0d: got %b required %b", o, overflow, ovf_m);
    else n_pass++;
`endif
    acc_m  = exp_acc;
    skip_m = exp_skip;
    @(negedge clk);
  endtask

  task automatic check_acc(input string name, input logic [WIDTH-1:0] exp);
    n_checks++;
    if (acc !== exp) $display("FAIL %s: acc=%h required %h", name, acc, exp);
    else n_pass++;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; op = '0; operand = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || acc !== '0 || skip !== 1'b0 ||
        alu_a !== '0 || alu_b !== '0 || alu_sub !== 1'b0 || alu_oe_n !== 1'b1)
      $display("FAIL reset_state: busy=%b done=%b acc=%h skip=%b a=%h b=%h sub=%b oe_n=%b required 0/0/0/0/0/0/0/1",
               busy, done, acc, skip, alu_a, alu_b, alu_sub, alu_oe_n);
    else n_pass++;
`ifdef ALU_SEQ_OVERFLOW_EN
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b required 0", overflow);
    else n_pass++;
`endif
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arith;
    run_op(OP_LDN, 32'h00000005, 0); check_acc("ldn_5", 32'hFFFFFFFB);
    run_op(OP_LDN, 32'hFFFFFFF6, 0); check_acc("ldn_to_a", 32'h0000000A);
    run_op(OP_SUB, 32'h00000004, 0); check_acc("sub_4", 32'h00000006);
    run_op(OP_ADD, 32'hFFFFFFFA, 0); check_acc("add_wrap", 32'h00000000);
  endtask

  task automatic test_cmp;
    run_op(OP_LDN, 32'h00000005, 0);
    run_op(OP_CMP, $urandom, 0);
    check_acc("cmp_neg_acc", 32'hFFFFFFFB);
    n_checks++;
    if (skip !== 1'b1) $display("FAIL cmp_neg_skip: got %b required 1", skip);
    else n_pass++;
    run_op(OP_LDN, 32'hFFFFFFFA, 0);
    run_op(OP_CMP, $urandom, 0);
    n_checks++;
    if (skip !== 1'b0) $display("FAIL cmp_pos_skip: got %b required 0", skip);
    else n_pass++;
  endtask

  task automatic test_ignore_busy;
    int extra;
    run_op(OP_LDN, 32'h00000010, 0);
    run_op(OP_SUB, 32'h00000003, 3);
    check_acc("ignore_acc", 32'hFFFFFFED);
    extra = 0;
    repeat (SETTLE + 5) begin
      if (done === 1'b1) extra++;
      @(negedge clk);
    end
    n_checks++;
    if (extra !== 0) $display("FAIL no_queue: got %0d extra done pulses required 0", extra);
    else n_pass++;
  endtask

  task automatic test_random;
    for (int i = 0; i < 30; i++) begin
      run_op(2'($urandom), $urandom, 0);
    end
  endtask

  task automatic test_reset_midop;
    int dones;
    run_op(OP_LDN, 32'h00000009, 0);
    start = 1'b1; op = OP_SUB; operand = $urandom;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || acc !== '0 || alu_oe_n !== 1'b1)
      $display("FAIL reset_midop: busy=%b done=%b acc=%h oe_n=%b required 0/0/0/1", busy, done, acc, alu_oe_n);
    else n_pass++;
    acc_m = '0; skip_m = 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
    ovf_m = 1'b0;
`endif
    dones = 0;
    repeat (SETTLE + 5) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones !== 0) $display("FAIL reset_no_done: got %0d done pulses required 0", dones);
    else n_pass++;
    run_op(OP_LDN, 32'h00000001, 0);
    check_acc("after_reset_ldn", 32'hFFFFFFFF);
  endtask

`ifdef ALU_SEQ_OVERFLOW_EN
  task automatic test_overflow;
    run_op(OP_LDN, 32'h80000001, 0); check_acc("ovf_load", 32'h7FFFFFFF);
    run_op(OP_ADD, 32'h00000001, 0); check_acc("ovf_add", 32'h80000000);
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_add_flag: got %b required 1", overflow);
    else n_pass++;
    run_op(OP_SUB, 32'h00000001, 0); check_acc("ovf_sub", 32'h7FFFFFFF);
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_sub_flag: got %b required 1", overflow);
    else n_pass++;
    run_op(OP_CMP, 32'h0, 0);
    n_checks++;
    if (overflow !== 1'b1) $display("FAIL ovf_cmp_hold: got %b required 1", overflow);
    else n_pass++;
    run_op(OP_ADD, 32'h00000000, 0);
    n_checks++;
    if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b required 0", overflow);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_arith();
    test_cmp();
    test_ignore_busy();
    test_random();
    test_reset_midop();
`ifdef ALU_SEQ_OVERFLOW_EN
    test_overflow();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Initiator/controller side of the ALU interface: drives the ALU operand buses and the SUB and OE_n controls, and captures the ALU RESULT into the accumulator.
- Executes the Manchester Baby arithmetic micro-ops LDN, SUB and CMP, plus ADD, under a start/done handshake from the control unit.
- Sits between the control/decode logic and the combinational ALU.
- Waits a programmable number of clocks for TTL propagation before latching RESULT.

Parameters:
WIDTH, 32, datapath width (ALU operand and result width, accumulator width).
SETTLE_CYCLES, 2, clocks to wait after driving the ALU before capture; legal range 1..15.

Ports:
clk  input  1  system clock; all logic is rising-edge.
reset  input  1  synchronous, active-high reset.
start  input  1  request an operation; sampled only in IDLE.
op  input  2  operation: 00 LDN, 01 SUB, 10 ADD, 11 CMP; sampled with start.
operand  input  WIDTH  store word; sampled with start.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse when the operation completes.
acc  output  WIDTH  accumulator.
skip  output  1  CMP result: acc is negative.
alu_a  output  WIDTH  ALU A operand.
alu_b  output  WIDTH  ALU B operand.
alu_sub  output  1  ALU subtract select.
alu_oe_n  output  1  ALU output enable, active-low.
alu_result  input  WIDTH  ALU RESULT bus.

Behaviour:
- Reset (synchronous, active-high; any state, including mid-operation):
  - state IDLE, acc=0, skip=0, busy=0, done=0.
  - alu_a=0, alu_b=0, alu_sub=0, alu_oe_n=1.
  - Settle counter cleared. Any operation in flight is abandoned; acc is not written.
- Operand and op are latched internally on accept. Later changes to start, op and operand are ignored until done.
- State machine (one-hot or encoded), states IDLE, DRIVE, SETTLE, CAPTURE, DONE:
  - IDLE: start=1 with op!=CMP goes to DRIVE. start=1 with op=CMP goes to DONE and registers skip<=acc[WIDTH-1]. start=0 stays in IDLE.
  - DRIVE (1 cycle): registers the ALU inputs, then goes to SETTLE.
    - LDN: alu_a=0, alu_b=operand, alu_sub=1.
    - SUB: alu_a=acc, alu_b=operand, alu_sub=1.
    - ADD: alu_a=acc, alu_b=operand, alu_sub=0.
    - alu_oe_n=0 in all three cases.
  - SETTLE: counts SETTLE_CYCLES clocks, then goes to CAPTURE.
  - CAPTURE: acc<=alu_result, alu_oe_n<=1, then goes to DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then goes to IDLE.
- alu_a, alu_b and alu_sub hold their values until the next DRIVE. alu_oe_n is low only from DRIVE through CAPTURE.
- Latency, start accepted to done high:
  - arithmetic ops: SETTLE_CYCLES+3 cycles.
  - CMP: 1 cycle.
- busy is high in DRIVE, SETTLE and CAPTURE.
- start while busy or in DONE: ignored, with no queueing.
- Back-to-back: start may be asserted in the cycle after done and is accepted.
- skip is written only by CMP and holds across other ops.
- Arithmetic is modulo 2^WIDTH; wrap-around is not flagged unless the optional feature is enabled.
- alu_result is sampled only in CAPTURE. High-Z or X values outside CAPTURE have no effect.

Optional Feature:
- Macro: ALU_SEQ_OVERFLOW_EN.
- Defined:
  - Adds output port overflow (1 bit, reset 0).
  - In CAPTURE, overflow is set to the signed overflow of the executed op:
    - ADD: alu_a and alu_b have the same sign and the result sign differs.
    - SUB/LDN: alu_a and alu_b signs differ and the result sign differs from alu_a.
  - overflow holds until the next arithmetic CAPTURE. CMP leaves it unchanged.
- Undefined: the port is absent and no overflow logic is built.

Decomposition:
- Shared package: op encodings OP_LDN, OP_SUB, OP_ADD, OP_CMP; state encoding; default WIDTH of 32.
- One sub-module, alu_seq_settle_timer: loadable down-counter producing an expired pulse; reused later by the store/memory sequencing.
- Testbench instantiates the existing alu with alu_seq outputs wired to A, B, SUB and OE_n, and RESULT wired to alu_result.

Test Plan:
- Reset, then LDN with operand=0x00000005 -> done after SETTLE_CYCLES+3 cycles; acc=0xFFFFFFFB; alu_oe_n=1 after CAPTURE.
- acc=0x0000000A, SUB with operand=0x00000004 -> acc=0x00000006. Then ADD with operand=0xFFFFFFFA -> acc=0x00000000.
- acc=0xFFFFFFFB, CMP -> done one cycle after accept, skip=1, acc unchanged. Then acc=0x00000006, CMP -> skip=0.
- start pulsed during SETTLE with op=ADD, operand=0x12345678 -> ignored; single done; acc reflects only the first op. Back-to-back start the cycle after done -> accepted.
- reset asserted during SETTLE of a SUB -> next cycle: state IDLE, acc=0, alu_oe_n=1, busy=0, no done pulse.
- With ALU_SEQ_OVERFLOW_EN: acc=0x7FFFFFFF, ADD 0x00000001 -> acc=0x80000000, overflow=1. Then SUB 0x00000001 -> acc=0x7FFFFFFF, overflow=1. Then ADD 0 -> overflow=0.
